mod10_counter: RTL and testbench

//   Loadable mod-10 up/down counter: the DUT end of the counter interface (the driver side

---
 rtl/counter_pkg.sv | 11 +
 rtl/mod10_next_state.sv | 61 ++++++
 rtl/mod10_counter.sv | 74 +++++++
 tb/tb_mod10_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the mod-10 counter and its bench.
package counter_pkg;
    localparam logic [3:0] MOD10_MAX = 4'd9;

    typedef logic [3:0] count_t;

    typedef enum logic {
        DN = 1'b0,
        UP = 1'b1
    } mode_e;
endpackage

// File: rtl/mod10_next_state.sv
// Next-count logic for the mod-N up/down counter: load, count, wrap.
module mod10_next_state
    import counter_pkg::*;
#(
    parameter int MODULUS = int'(MOD10_MAX) + 1
) (
    input  count_t     count,
    input  logic       mode,
    input  logic       load,
    input  count_t     data_in,
    output count_t     next_count,
    output logic       wrap,
    output logic       bad_load
);
    localparam logic [4:0] LAST = 5'(MODULUS - 1);
    localparam logic [4:0] LIM  = 5'(MODULUS);

    logic [4:0] cnt5;
    logic       in_ok;
    logic       is_up;
    logic       sel_bad;
    logic       sel_ld;
    logic       sel_upw;
    logic       sel_up;
    logic       sel_dnw;
    logic       sel_dn;

    always_comb begin
        cnt5    = {1'b0, count};
        in_ok   = ({1'b0, data_in} < LIM);
        is_up   = (mode_e'(mode) == UP);
        sel_bad = load && !in_ok;
        sel_ld  = load && in_ok;
        sel_upw = !load && is_up && (cnt5 == LAST);
        sel_up  = !load && is_up && (cnt5 != LAST);
        sel_dnw = !load && !is_up && (cnt5 == 5'd0);
        sel_dn  = !load && !is_up && (cnt5 != 5'd0);
    end

    // Arithmetic stays in 5 bits; terminal values are caught explicitly.
    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        bad_load   = 1'b0;
        unique case (1'b1)
            sel_bad: bad_load = 1'b1;
            sel_ld:  next_count = data_in;
            sel_upw: begin
                next_count = '0;
                wrap       = 1'b1;
            end
            sel_up:  next_count = 4'(cnt5 + 5'd1);
            sel_dnw: begin
                next_count = 4'(LAST);
                wrap       = 1'b1;
            end
            sel_dn:  next_count = 4'(cnt5 - 5'd1);
            default: next_count = count;
        endcase
    end
endmodule

// File: rtl/mod10_counter.sv
// Loadable mod-10 up/down counter with tc and load_err pulses.
// Optional saturating wrap counter enabled by COUNTER_WRAP_CNT_EN.
module mod10_counter
    import counter_pkg::*;
#(
    parameter int MODULUS = int'(MOD10_MAX) + 1,
    parameter int WRAP_W  = 8
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              mode,
    input  logic              load,
    input  logic [3:0]        data_in,
    output logic [3:0]        data_out,
    output logic              tc,
`ifdef COUNTER_WRAP_CNT_EN
    output logic              load_err,
    output logic [WRAP_W-1:0] wrap_cnt
`else
    output logic              load_err
`endif
);
    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_mod
        $error("MODULUS must be in 2..16");
    end
    if (WRAP_W < 1) begin : g_bad_w
        $error("WRAP_W must be at least 1");
    end

    count_t next_count;
    logic   wrap;
    logic   bad_load;

    mod10_next_state #(
        .MODULUS(MODULUS)
    ) u_next (
        .count     (data_out),
        .mode      (mode),
        .load      (load),
        .data_in   (data_in),
        .next_count(next_count),
        .wrap      (wrap),
        .bad_load  (bad_load)
    );

    always_ff @(posedge clock) begin
        if (!rst) begin
            data_out <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            data_out <= next_count;
            tc       <= wrap;
            load_err <= bad_load;
        end
    end

`ifdef COUNTER_WRAP_CNT_EN
    always_ff @(posedge clock) begin
        if (!rst) begin
            wrap_cnt <= '0;
        end else if (wrap && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    localparam count_t LAST = count_t'(MODULUS - 1);
    a_range: assert property (
        @(posedge clock) data_out <= LAST
    );
`endif
endmodule

// File: tb/tb_mod10_counter.sv
// Scoreboard bench for mod10_counter: directed boundaries plus random traffic.
module tb_mod10_counter;
    import counter_pkg::*;

    localparam int MODULUS = int'(MOD10_MAX) + 1;
    localparam int WRAP_W  = 8;
    localparam int WMAX    = (1 << WRAP_W) - 1;

    logic              clock = 1'b0;
    logic              rst = 1'b0;
    logic              mode = 1'b0;
    logic              load = 1'b0;
    logic [3:0]        data_in = 4'd0;
    logic [3:0]        data_out;
    logic              tc;
    logic              load_err;
    logic [WRAP_W-1:0] got_w;

`ifdef COUNTER_WRAP_CNT_EN
    logic [WRAP_W-1:0] wrap_cnt;
    assign got_w = wrap_cnt;
`else
    assign got_w = '0;
`endif

    mod10_counter #(
        .MODULUS(MODULUS),
        .WRAP_W (WRAP_W)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .mode    (mode),
        .load    (load),
        .data_in (data_in),
        .data_out(data_out),
        .tc      (tc),
`ifdef COUNTER_WRAP_CNT_EN
        .load_err(load_err),
        .wrap_cnt(wrap_cnt)
`else
        .load_err(load_err)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]        d;
        logic              tc;
        logic              err;
        logic [WRAP_W-1:0] w;
    } exp_t;

    exp_t q[$];
    exp_t e;
    exp_t g;
    int   checks = 0;
    int   fails  = 0;
    int   m_cnt  = 0;
    int   m_wraps = 0;

    // Reference: the counter value as a plain integer modulo MODULUS.
    task automatic step(input logic r, input logic md,
                        input logic ld, input logic [3:0] di);
        exp_t x;
        @(negedge clock);
        rst = r;
        mode = md;
        load = ld;
        data_in = di;
        x = '0;
        if (!r) begin
            m_cnt = 0;
            m_wraps = 0;
        end else if (ld) begin
            if (int'(di) < MODULUS) m_cnt = int'(di);
            else x.err = 1'b1;
        end else if (md) begin
            x.tc = (m_cnt == MODULUS - 1);
            m_cnt = (m_cnt + 1) % MODULUS;
        end else begin
            x.tc = (m_cnt == 0);
            m_cnt = (m_cnt + MODULUS - 1) % MODULUS;
        end
        if (x.tc) m_wraps++;
        x.d = 4'(m_cnt);
`ifdef COUNTER_WRAP_CNT_EN
        x.w = (m_wraps > WMAX) ? WRAP_W'(WMAX) : WRAP_W'(m_wraps);
`else
        x.w = '0;
`endif
        q.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                g = {data_out, tc, load_err, got_w};
                checks++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL cycle t=%0t: got d=%0d tc=%0b err=%0b w=%0d, want d=%0d tc=%0b err=%0b w=%0d",
                             $time, g.d, g.tc, g.err, g.w,
                             e.d, e.tc, e.err, e.w);
                end
            end
        end
    end

    initial begin
        // reset with load noise
        step(0, 1, 1, 4'd5);
        step(0, 1, 1, 4'd5);
        // count up through the wrap
        step(1, 1, 1, 4'd7);
        repeat (4) step(1, 1, 0, 4'd0);
        // count down through the wrap
        step(1, 0, 1, 4'd1);
        repeat (3) step(1, 0, 0, 4'd0);
        // illegal loads
        step(1, 1, 1, 4'd4);
        step(1, 1, 1, 4'd12);
        step(1, 1, 0, 4'd0);
        step(1, 1, 1, 4'd4);
        step(1, 1, 1, 4'd15);
        step(1, 0, 0, 4'd0);
        // reset beats load
        step(1, 1, 1, 4'd6);
        step(0, 1, 1, 4'd3);
        step(1, 1, 0, 4'd0);
        // load at terminal value, then mode flip
        step(1, 1, 1, 4'd9);
        step(1, 1, 1, 4'd2);
        step(1, 1, 1, 4'd5);
        step(1, 0, 0, 4'd0);
        // 300 wraps drive wrap_cnt into saturation
        step(0, 1, 0, 4'd0);
        repeat (3000) step(1, 1, 0, 4'd0);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 49) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)));
        end
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
